// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the two-port burst memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_t;

   // Byte offset of a word inside a line address
   localparam int WORD_OFFSET = 2;

   // Counter width for a 0..n-1 count, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin pick; the priority pointer is held by the caller.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic  i_req_i,
   input  logic  i_req_d,
   input  port_t i_ptr,
   output port_t o_gnt,
   output logic  o_valid
);

   // Tie goes to the pointer's port, otherwise the lone requester wins
   always_comb begin
      o_valid = i_req_i | i_req_d;
      o_gnt   = PORT_I;
      if (i_req_i && i_req_d) begin
         o_gnt = i_ptr;
      end else if (i_req_d) begin
         o_gnt = PORT_D;
      end else begin
         o_gnt = PORT_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the I and D cache engines, one
// BURST_LEN-word burst per grant, each word held for MEM_LATENCY cycles.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int BURST_LEN   = 4,
   parameter int MEM_LATENCY = 2
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              ireq,
   input  logic                              iwrite_en,
   input  logic [31:0]                       iaddr,
   input  logic [31:0]                       idata,
   output logic [cnt_width(BURST_LEN)-1:0]   iword,
   output logic [31:0]                       iout,
   output logic                              ivalid,
   output logic                              idone,
   input  logic                              dreq,
   input  logic                              dwrite_en,
   input  logic [31:0]                       daddr,
   input  logic [31:0]                       ddata,
   output logic [cnt_width(BURST_LEN)-1:0]   dword,
   output logic [31:0]                       dout,
   output logic                              dvalid,
   output logic                              ddone,
   output logic                              mwrite_en,
   output logic [31:0]                       maddr,
   output logic [31:0]                       mdata,
   input  logic [31:0]                       mout
);

   localparam int          CW        = cnt_width(BURST_LEN);
   localparam int          LW        = cnt_width(MEM_LATENCY);
   localparam logic [31:0] LINE_MASK = 32'((BURST_LEN << WORD_OFFSET) - 1);

   state_t          r_state;
   state_t          w_next_state;
   port_t           r_grant;
   port_t           r_ptr;
   port_t           w_gnt;
   logic            w_gnt_valid;
   logic            r_write;
   logic [31:0]     r_base;
   logic [CW-1:0]   r_wordcnt;
   logic [LW-1:0]   r_latcnt;
   logic [31:0]     r_iout;
   logic [31:0]     r_dout;
   logic            r_ivalid;
   logic            r_dvalid;
   logic            w_last_lat;
   logic            w_last_word;

   rr_arbiter2 u_rr (
      .i_req_i (ireq),
      .i_req_d (dreq),
      .i_ptr   (r_ptr),
      .o_gnt   (w_gnt),
      .o_valid (w_gnt_valid)
   );

   assign w_last_lat  = (r_state == ACCESS) && (r_latcnt == LW'(MEM_LATENCY - 1));
   assign w_last_word = (r_wordcnt == CW'(BURST_LEN - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_gnt_valid) begin
               w_next_state = ACCESS;
            end else begin
               w_next_state = IDLE;
            end
         end
         ACCESS: begin
            if (w_last_lat && w_last_word) begin
               w_next_state = DONE;
            end else begin
               w_next_state = ACCESS;
            end
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Grant latching, word/latency counters and read-data capture
   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant   <= PORT_I;
         r_ptr     <= PORT_I;
         r_write   <= 1'b0;
         r_base    <= 32'd0;
         r_wordcnt <= '0;
         r_latcnt  <= '0;
         r_iout    <= 32'd0;
         r_dout    <= 32'd0;
         r_ivalid  <= 1'b0;
         r_dvalid  <= 1'b0;
      end else begin
         r_ivalid <= 1'b0;
         r_dvalid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_gnt_valid) begin
                  r_grant   <= w_gnt;
                  r_ptr     <= (w_gnt == PORT_I) ? PORT_D : PORT_I;
                  r_write   <= (w_gnt == PORT_I) ? iwrite_en : dwrite_en;
                  r_base    <= ((w_gnt == PORT_I) ? iaddr : daddr) & ~LINE_MASK;
                  r_wordcnt <= '0;
                  r_latcnt  <= '0;
               end
            end
            ACCESS: begin
               if (w_last_lat) begin
                  r_latcnt  <= '0;
                  r_wordcnt <= r_wordcnt + CW'(1);
                  // Writes are acknowledged through the same capture path
                  if (r_grant == PORT_I) begin
                     r_iout   <= mout;
                     r_ivalid <= 1'b1;
                  end else begin
                     r_dout   <= mout;
                     r_dvalid <= 1'b1;
                  end
               end else begin
                  r_latcnt <= r_latcnt + LW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Memory-side drive and per-port word index, all quiet outside ACCESS
   always_comb begin
      maddr     = 32'd0;
      mdata     = 32'd0;
      mwrite_en = 1'b0;
      iword     = '0;
      dword     = '0;
      if (r_state == ACCESS) begin
         maddr     = r_base | (32'(r_wordcnt) << WORD_OFFSET);
         mwrite_en = r_write & w_last_lat;
         if (r_grant == PORT_I) begin
            mdata = idata;
            iword = r_wordcnt;
         end else begin
            mdata = ddata;
            dword = r_wordcnt;
         end
      end else begin
         maddr     = 32'd0;
         mwrite_en = 1'b0;
      end
   end

   assign iout   = r_iout;
   assign dout   = r_dout;
   assign ivalid = r_ivalid;
   assign dvalid = r_dvalid;
   assign idone  = (r_state == DONE) && (r_grant == PORT_I);
   assign ddone  = (r_state == DONE) && (r_grant == PORT_D);

endmodule
